// File: rtl/ri_run_sequencer_pkg.sv
// Shared JPEG-LS run-mode parameters: J table, sequencer state codes and
// interface widths used by the run-interruption sequencer.
package ri_run_sequencer_pkg;

    localparam int QBPP  = 8;
    localparam int LIMIT = 32;

    localparam int RUN_IDX_W  = 5;
    localparam int J_W        = 4;
    localparam int RI_PIXEL_W = 10;
    localparam int RI_LEN_W   = 6;
    localparam int RI_REM_W   = 10;
    localparam int OUT_LEN_W  = 5;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ONES = 3'd1;
    localparam logic [2:0] S_TAIL = 3'd2;
    localparam logic [2:0] S_RI   = 3'd3;
    localparam logic [2:0] S_REM  = 3'd4;

    localparam logic [J_W-1:0] J_TABLE [0:31] = '{
        4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1,
        4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3,
        4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7,
        4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic logic [J_W-1:0] j_of(input logic [RUN_IDX_W-1:0] idx);
        return J_TABLE[idx];
    endfunction

endpackage

// File: rtl/ri_run_sequencer.sv
// Turns a terminated run into bit-field beats: run-length '1's, the tail
// (J bits + '0'), then the external RI encoder's codeword and remainder.
module ri_run_sequencer
    import ri_run_sequencer_pkg::*;
#(
    parameter int RUNCOUNT_W = 16,
    parameter int OUT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [RUNCOUNT_W-1:0] runcount,
    input  logic                  eol,
    output logic [J_W-1:0]        ri_J,
    input  logic [RI_PIXEL_W-1:0] ri_pixel,
    input  logic [RI_LEN_W-1:0]   ri_length,
    input  logic                  ri_overflow,
    input  logic [RI_REM_W-1:0]   ri_remainder,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_bits,
    output logic [OUT_LEN_W-1:0]  out_len,
    output logic [RUN_IDX_W-1:0]  run_index
);

    state_t                  state;
    logic [RUNCOUNT_W-1:0]   rem_cnt;
    logic                    eol_q;

    logic [J_W-1:0]          j_cur;
    logic [J_W-1:0]          j_inc;
    logic [RUNCOUNT_W:0]     step;
    logic                    full;
    logic [RUNCOUNT_W-1:0]   rem_sub;
    logic [RUNCOUNT_W-1:0]   tail_field;
    logic [RUN_IDX_W-1:0]    idx_inc;
    logic [RUN_IDX_W-1:0]    idx_dec;
    logic                    unused_len_msb;

    // Chooses the state that follows once rem_cnt is known: another '1',
    // the end-of-line closing '1', nothing at all, or the tail.
    function automatic state_t classify(input logic [RUNCOUNT_W-1:0] rem,
                                        input logic [J_W-1:0] j,
                                        input logic e);
        logic [RUNCOUNT_W:0] stp;
        stp = {{RUNCOUNT_W{1'b0}}, 1'b1} << j;
        if ({1'b0, rem} >= stp)
            return S_ONES;
        else if (e)
            return (rem != '0) ? S_ONES : S_IDLE;
        else
            return S_TAIL;
    endfunction

    assign j_cur      = j_of(run_index);
    assign ri_J       = j_cur;
    assign step       = {{RUNCOUNT_W{1'b0}}, 1'b1} << j_cur;
    assign full       = {1'b0, rem_cnt} >= step;
    assign rem_sub    = rem_cnt - step[RUNCOUNT_W-1:0];
    assign tail_field = rem_cnt & ~({RUNCOUNT_W{1'b1}} << j_cur);
    assign idx_inc    = (run_index == 5'd31) ? 5'd31 : run_index + 5'd1;
    assign idx_dec    = (run_index != '0) ? run_index - 5'd1 : '0;
    assign j_inc      = j_of(idx_inc);

    assign unused_len_msb = ri_length[RI_LEN_W-1];

    assign job_ready = reset_n && (state == S_IDLE);
    assign out_valid = (state != S_IDLE);

    always_comb begin
        out_bits = '0;
        out_len  = '0;
        case (state)
            S_ONES: begin
                out_bits = OUT_W'(1);
                out_len  = 5'd1;
            end
            S_TAIL: begin
                out_bits = OUT_W'({tail_field, 1'b0});
                out_len  = 5'(j_cur) + 5'd1;
            end
            S_RI: begin
                out_bits = OUT_W'(ri_pixel);
                out_len  = ri_length[OUT_LEN_W-1:0];
            end
            S_REM: begin
                out_bits = OUT_W'(ri_remainder);
                out_len  = 5'd9;
            end
            default: ;
        endcase
    end

    // The next state is resolved on each accept, so every non-IDLE cycle
    // carries a beat and the first beat is valid right after job accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            run_index <= '0;
            rem_cnt   <= '0;
            eol_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        rem_cnt <= runcount;
                        eol_q   <= eol;
                        state   <= classify(runcount, j_cur, eol);
                    end
                end
                S_ONES: begin
                    if (out_ready) begin
                        if (full) begin
                            rem_cnt   <= rem_sub;
                            run_index <= idx_inc;
                            state     <= classify(rem_sub, j_inc, eol_q);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_TAIL: begin
                    if (out_ready)
                        state <= S_RI;
                end
                S_RI: begin
                    if (out_ready) begin
                        if (ri_overflow) begin
                            state <= S_REM;
                        end else begin
                            state     <= S_IDLE;
                            run_index <= idx_dec;
                        end
                    end
                end
                S_REM: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        run_index <= idx_dec;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ri_run_sequencer.md
RI_RUN_SEQUENCER -- requirements
Module: ri_run_sequencer

Interface
REQ-001 SHALL have parameter RUNCOUNT_W, default 16: width of the run-length count.
REQ-002 SHALL have parameter OUT_W, default 16: width of the emitted bit-field beat.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port job_valid, input, 1 bit: run job offered.
REQ-006 SHALL have port job_ready, output, 1 bit: sequencer accepts a job; high only in IDLE.
REQ-007 SHALL have port runcount, input, RUNCOUNT_W bits: length of the terminated run.
REQ-008 SHALL have port eol, input, 1 bit: the run ended at end of line, so no interruption sample follows.
REQ-009 SHALL have port ri_J, output, 4 bits: J[RUNindex] driven to the RI encoder.
REQ-010 SHALL have ports ri_pixel (10 bits), ri_length (6 bits), ri_overflow (1 bit) and ri_remainder (10 bits), all inputs: the combinational results of the RI encoder.
REQ-011 SHALL have port out_valid, output, 1 bit: a beat is present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-013 SHALL have port out_bits, output, OUT_W bits: beat payload, LSB-aligned.
REQ-014 SHALL have port out_len, output, 5 bits: number of valid bits in out_bits.
REQ-015 SHALL have port run_index, output, 5 bits: current RUNindex.

Function
REQ-016 SHALL define the J table by index 0..31 as: 0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 4,4, 5,5, 6,6, 7,7, 8,9,10,11,12,13,14,15.
REQ-017 SHALL drive ri_J = J[run_index] combinationally at all times.
REQ-018 SHALL implement the states IDLE, ONES, TAIL, RI, REM.
REQ-019 SHALL accept a job on job_valid&&job_ready, latching runcount into rem_cnt and latching eol, then enter ONES.
REQ-020 In ONES, if rem_cnt >= (1<<J), SHALL emit a beat of bits=1, len=1; on acceptance SHALL subtract (1<<J) from rem_cnt and increment run_index, saturating at 31.
REQ-021 In ONES, if rem_cnt < (1<<J) and eol=1, SHALL emit bits=1, len=1 when rem_cnt > 0 then go to IDLE, or go directly to IDLE with no beat when rem_cnt = 0.
REQ-022 In ONES, if rem_cnt < (1<<J) and eol=0, SHALL go to TAIL.
REQ-023 In TAIL, SHALL emit bits={rem_cnt[J-1:0],1'b0}, len=J+1, with the '0' in LSB emitted first, then go to RI.
REQ-024 In RI, SHALL emit bits=ri_pixel, len=ri_length; on acceptance SHALL go to REM if ri_overflow=1, else to IDLE.
REQ-025 In REM, SHALL emit bits=ri_remainder, len=9, then go to IDLE.
REQ-026 On leaving RI (no overflow) or REM, SHALL decrement run_index when it is greater than 0.
REQ-027 SHALL use the J value for all RI/REM beats from the index current at TAIL exit.
REQ-028 SHALL emit one beat per state visit.
REQ-029 SHALL hold out_bits/out_len stable while out_valid&&!out_ready.
REQ-030 SHALL never drop out_valid before acceptance.
REQ-031 SHALL allow a new job in the cycle after the final beat is accepted, giving a minimum of 1 cycle in IDLE.
REQ-032 SHALL make the first beat valid the cycle after job acceptance.
REQ-033 SHALL retain run_index across jobs; software/line logic does not reset it.

Reset
REQ-034 On reset_n=0, SHALL asynchronously set state to IDLE, run_index to 0, and rem_cnt and eol to 0.
REQ-035 On reset_n=0, SHALL drive out_valid=0, out_bits=0, out_len=0 and job_ready=0 during reset.
REQ-036 SHALL set job_ready=1 the first cycle after release.
REQ-037 A reset asserted mid-job SHALL abandon the job without emitting a partial beat.

Structure
REQ-038 SHALL place the J table, the state enum, qbpp=8, limit=32 and the port widths in the shared JPEG-LS parameter package.
REQ-039 SHALL instantiate no sub-module; the RI encoder stays external and its outputs are sampled only in the RI/REM states.

Verification
REQ-040 With run_index=0, runcount=3, eol=0 and ri_pixel=0b101/len=3: SHALL emit beats 1,1,1, then TAIL bits=0/len=1 (J[3]=0), then 101/len=3, and end with run_index=2.
REQ-041 With run_index=4, runcount=5, eol=0: SHALL emit 1 (subtract 2, run_index 5), 1 (subtract 2, run_index 6), then TAIL bits={1,0}/len=2, then the RI beat, ending with run_index=5.
REQ-042 With eol=1, runcount=1 at run_index=4: SHALL emit a single '1', skip TAIL/RI, and leave run_index=4.
REQ-043 With eol=1 and runcount=0: SHALL emit no beats, and job_ready SHALL return to 1 in the next cycle.
REQ-044 With ri_overflow=1 and ri_remainder=0x1A3: SHALL emit the RI beat then REM bits=0x1A3/len=9, while out_ready is toggled 0/1 every cycle so that payload stability is checked.
REQ-045 With runcount=0xFFFF: run_index SHALL saturate at 31 with no wrap; asserting reset_n=0 during ONES SHALL return to IDLE, run_index=0, and out_valid=0 immediately.
